ro_scan_meter: RTL and testbench

- Multi-channel successor to the single-counter ring-oscillator measurement path.
- Scans up to N_CH oscillator inputs selected by a channel mask and enables one oscillator at a time.
- Per channel: counts synchronized oscillator rising edges over a programmable gate window, repeats 2^AVG_LOG2 times, and publishes the truncated average with a valid/ack handshake.
- Sits between the ring oscillators and the controller/UART path; replaces the separate counter, averager and oscillator-select mux.

---
 rtl/ro_scan_pkg.sv | 37 +++
 rtl/ro_edge_sync.sv | 29 ++
 rtl/ro_scan_meter.sv | 194 +++++++++++++++++++
 tb/tb_ro_scan_meter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_scan_pkg.sv
// Shared types and helpers for the ring-oscillator scan meter: FSM state
// encoding, settle-time floor and the mask bit-search used to walk channels.
package ro_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_GATE,
    ST_ACCUM,
    ST_PUBLISH
  } state_e;

  // The edge path needs three clk cycles to flush after a mux change, plus one of margin.
  localparam int SETTLE_MIN_CYC = 4;
  localparam int MAX_CH         = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } bit_sel_t;

  // Lowest set bit of mask at index >= from; found = 0 when there is none.
  function automatic bit_sel_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                            input logic [4:0]        from);
    bit_sel_t sel;
    sel = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        sel.found = 1'b1;
        sel.idx   = 4'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for the selected oscillator followed by a rising-edge
// detector; rise_o is a single-cycle pulse in the clk domain.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/ro_scan_meter.sv
// Multi-channel ring-oscillator meter: sweeps the masked channels one at a
// time, averages 2^AVG_LOG2 gated edge counts each, and hands out results.
module ro_scan_meter
  import ro_scan_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    start_i,
  input  logic                    continuous_i,
  input  logic [N_CH-1:0]         cfg_mask_i,
  input  logic [WIN_W-1:0]        cfg_window_i,
  input  logic [N_CH-1:0]         osc_in_i,
  output logic [N_CH-1:0]         osc_en_o,
  output logic                    busy_o,
  output logic                    result_valid_o,
  input  logic                    result_ack_i,
  output logic [$clog2(N_CH)-1:0] result_ch_o,
  output logic [CNT_W-1:0]        result_data_o,
  output logic                    result_sat_o
);

  localparam int CH_W       = $clog2(N_CH);
  localparam int ACC_W      = CNT_W + AVG_LOG2;
  localparam int ITER_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SETTLE_EFF = (SETTLE_CYC < SETTLE_MIN_CYC) ? SETTLE_MIN_CYC : SETTLE_CYC;
  localparam int SET_W      = $clog2(SETTLE_EFF);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_EFF - 1);

  state_e             state_q,   state_d;
  logic [N_CH-1:0]    mask_q,    mask_d;
  logic [WIN_W-1:0]   win_q,     win_d;
  logic [CH_W-1:0]    ptr_q,     ptr_d;
  logic [SET_W-1:0]   settle_q,  settle_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [ITER_W-1:0]  iter_q,    iter_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic               sat_q,     sat_d;

  logic     osc_sel;
  logic     edge_rise;
  bit_sel_t first_sel;
  bit_sel_t next_sel;
  bit_sel_t wrap_sel;

  // Single shared edge path; SETTLE covers its flush after every channel switch.
  assign osc_sel = osc_in_i[ptr_q];

  ro_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (osc_sel),
    .rise_o (edge_rise)
  );

  assign first_sel = next_set_bit(MAX_CH'(cfg_mask_i), 5'd0);
  assign next_sel  = next_set_bit(MAX_CH'(mask_q), 5'(ptr_q) + 5'd1);
  assign wrap_sel  = next_set_bit(MAX_CH'(mask_q), 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      settle_q  <= '0;
      win_cnt_q <= '0;
      iter_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      settle_q  <= settle_d;
      win_cnt_q <= win_cnt_d;
      iter_q    <= iter_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d   = state_q;
    mask_d    = mask_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    settle_d  = settle_q;
    win_cnt_d = win_cnt_q;
    iter_d    = iter_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sat_d     = sat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && first_sel.found) begin
          mask_d  = cfg_mask_i;
          win_d   = (cfg_window_i == '0) ? WIN_W'(1) : cfg_window_i;
          ptr_d   = CH_W'(first_sel.idx);
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        settle_d  = '0;
        win_cnt_d = '0;
        iter_d    = '0;
        cnt_d     = '0;
        acc_d     = '0;
        sat_d     = 1'b0;
        state_d   = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = ST_GATE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_GATE: begin
        // sat marks an edge lost because the count was already pinned at all-ones.
        if (edge_rise) begin
          if (cnt_q == '1) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (win_cnt_q == win_q - 1'b1) begin
          state_d = ST_ACCUM;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end

      ST_ACCUM: begin
        acc_d     = acc_q + ACC_W'(cnt_q);
        cnt_d     = '0;
        win_cnt_d = '0;
        if (iter_q == ITER_LAST) begin
          state_d = ST_PUBLISH;
        end else begin
          iter_d  = iter_q + 1'b1;
          state_d = ST_GATE;
        end
      end

      ST_PUBLISH: begin
        if (result_ack_i) begin
          if (next_sel.found) begin
            ptr_d   = CH_W'(next_sel.idx);
            state_d = ST_SELECT;
          end else if (continuous_i && wrap_sel.found) begin
            ptr_d   = CH_W'(wrap_sel.idx);
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything, including a result still waiting for ack.
    if (!en_i) begin
      state_d = ST_IDLE;
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = (state_q == ST_PUBLISH);
  assign osc_en_o       = busy_o ? (N_CH'(1) << ptr_q) : '0;
  assign result_ch_o    = ptr_q;
  assign result_data_o  = CNT_W'(acc_q >> AVG_LOG2);
  assign result_sat_o   = sat_q;

endmodule

// File: tb/tb_ro_scan_meter.sv
// Directed bench for ro_scan_meter: a 16-bit-count instance for timing, order,
// handshake and abort cases, and a 4-bit-count instance for saturation.
module tb_ro_scan_meter;

  localparam int N_CH   = 4;
  localparam int WIN_W  = 16;
  localparam int AVG    = 2;
  localparam int SETTLE = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             start_b = 1'b0;
  logic             continuous = 1'b0;
  logic [N_CH-1:0]  cfg_mask = '0;
  logic [WIN_W-1:0] cfg_window = '0;
  logic             ack = 1'b0;
  logic             ack_b = 1'b1;

  logic osc0 = 1'b0, osc1 = 1'b0, osc2 = 1'b0, oscf = 1'b0;
  logic [N_CH-1:0] osc_a, osc_b;

  logic [N_CH-1:0] a_osc_en, b_osc_en;
  logic            a_busy, a_valid, a_sat, b_busy, b_valid, b_sat;
  logic [1:0]      a_ch, b_ch;
  logic [15:0]     a_data;
  logic [3:0]      b_data;

  int checks = 0;
  int errors = 0;
  int onehot_bad = 0;

  always #5 clk = ~clk;

  // Oscillators: periods of 8, 8, 16 and 4 clk cycles, phases clear of clk edges.
  initial begin #3; forever #40 osc0 = ~osc0; end
  initial begin #7; forever #40 osc1 = ~osc1; end
  initial begin #3; forever #80 osc2 = ~osc2; end
  initial begin #3; forever #20 oscf = ~oscf; end

  assign osc_a = {1'b0, osc2, osc1, osc0};
  assign osc_b = {3'b000, oscf};

  ro_scan_meter #(.N_CH(N_CH), .CNT_W(16), .WIN_W(WIN_W), .AVG_LOG2(AVG), .SETTLE_CYC(SETTLE)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .start_i(start), .continuous_i(continuous),
    .cfg_mask_i(cfg_mask), .cfg_window_i(cfg_window), .osc_in_i(osc_a), .osc_en_o(a_osc_en),
    .busy_o(a_busy), .result_valid_o(a_valid), .result_ack_i(ack), .result_ch_o(a_ch),
    .result_data_o(a_data), .result_sat_o(a_sat)
  );

  ro_scan_meter #(.N_CH(N_CH), .CNT_W(4), .WIN_W(WIN_W), .AVG_LOG2(AVG), .SETTLE_CYC(SETTLE)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .start_i(start_b), .continuous_i(1'b0),
    .cfg_mask_i(cfg_mask), .cfg_window_i(cfg_window), .osc_in_i(osc_b), .osc_en_o(b_osc_en),
    .busy_o(b_busy), .result_valid_o(b_valid), .result_ack_i(ack_b), .result_ch_o(b_ch),
    .result_data_o(b_data), .result_sat_o(b_sat)
  );

  always @(negedge clk) begin
    if (!$onehot0(a_osc_en) || !$onehot0(b_osc_en)) onehot_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [N_CH-1:0] m, input logic [WIN_W-1:0] w);
    @(negedge clk);
    cfg_mask = m;
    cfg_window = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input bit use_b, input int max_cyc, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      @(posedge clk);
      #1;
      n++;
      ok = use_b ? b_valid : a_valid;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit ok;
    int cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_osc_en", a_osc_en, 0);
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_ch", a_ch, 0);
    check("rst_data", a_data, 0);
    check("rst_sat", a_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Single channel, latency 1 + 8 + 4*65 = 269
    pulse_start(4'b0001, 16'd64);
    check("t1_osc_en", a_osc_en, 4'b0001);
    check("t1_busy", a_busy, 1);
    wait_valid(0, 400, n, ok);
    check("t1_valid_seen", ok, 1);
    check("t1_latency", n, 269);
    check("t1_ch", a_ch, 0);
    check("t1_data", a_data, 8);
    check("t1_sat", a_sat, 0);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("t1_valid_drop", a_valid, 0);
    check("t1_idle_busy", a_busy, 0);
    check("t1_idle_osc_en", a_osc_en, 0);

    // Two channels, ack held high: (0,8) then (2,4)
    pulse_start(4'b0101, 16'd64);
    wait_valid(0, 400, n, ok);
    check("t2_first_seen", ok, 1);
    check("t2_first_ch", a_ch, 0);
    check("t2_first_data", a_data, 8);
    wait_valid(0, 400, n, ok);
    check("t2_second_seen", ok, 1);
    check("t2_second_ch", a_ch, 2);
    check("t2_second_data", a_data, 4);
    @(posedge clk);
    #1;
    check("t2_busy_end", a_busy, 0);
    check("t2_osc_en_end", a_osc_en, 0);

    // Saturation on the 4-bit instance: 50 edges per window clamp at 15
    @(negedge clk);
    cfg_mask = 4'b0001;
    cfg_window = 16'd200;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    check("t3_osc_en", b_osc_en, 4'b0001);
    wait_valid(1, 1200, n, ok);
    check("t3_valid_seen", ok, 1);
    check("t3_latency", n, 813);
    check("t3_ch", b_ch, 0);
    check("t3_data", b_data, 15);
    check("t3_sat", b_sat, 1);
    @(posedge clk);
    #1;
    check("t3_busy_end", b_busy, 0);

    // Ack withheld 50 cycles; restart and cfg changes mid-sweep are ignored
    ack = 1'b0;
    pulse_start(4'b0011, 16'd64);
    cfg_mask = 4'b1111;
    cfg_window = 16'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(0, 400, n, ok);
    check("t4_first_seen", ok, 1);
    check("t4_first_ch", a_ch, 0);
    check("t4_first_data", a_data, 8);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", a_valid, 1);
      check("t4_hold_ch", a_ch, 0);
      check("t4_hold_data", a_data, 8);
      check("t4_hold_osc_en", a_osc_en, 4'b0001);
    end
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    check("t4_valid_drop", a_valid, 0);
    check("t4_next_osc_en", a_osc_en, 4'b0010);
    wait_valid(0, 400, n, ok);
    check("t4_second_seen", ok, 1);
    check("t4_second_latency", n, 269);
    check("t4_second_ch", a_ch, 1);
    check("t4_second_data", a_data, 8);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("t4_busy_end", a_busy, 0);

    // Continuous sweep 0,1,0 then abort mid-gate
    continuous = 1'b1;
    pulse_start(4'b0011, 16'd64);
    wait_valid(0, 400, n, ok);
    check("t5_r0_ch", a_ch, 0);
    wait_valid(0, 400, n, ok);
    check("t5_r1_ch", a_ch, 1);
    wait_valid(0, 400, n, ok);
    check("t5_r2_ch", a_ch, 0);
    check("t5_r2_seen", ok, 1);
    repeat (30) @(posedge clk);
    #1;
    check("t5_gate_busy", a_busy, 1);
    check("t5_gate_osc_en", a_osc_en, 4'b0010);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("t5_abort_busy", a_busy, 0);
    check("t5_abort_osc_en", a_osc_en, 0);
    check("t5_abort_valid", a_valid, 0);
    cnt = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (a_valid || a_busy) cnt++;
    end
    check("t5_quiet_after_abort", cnt, 0);
    continuous = 1'b0;
    en = 1'b1;

    // Asynchronous reset mid-gate, then start with an empty mask
    ack = 1'b0;
    pulse_start(4'b0001, 16'd64);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_osc_en", a_osc_en, 0);
    check("t6_rst_valid", a_valid, 0);
    check("t6_rst_data", a_data, 0);
    check("t6_rst_sat", a_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(4'b0000, 16'd64);
    check("t6_empty_busy", a_busy, 0);
    check("t6_empty_osc_en", a_osc_en, 0);
    cnt = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (a_valid || a_busy) cnt++;
    end
    check("t6_stays_idle", cnt, 0);

    check("onehot_osc_en", onehot_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
